motor_pwm_timebase: RTL
=======================

# motor_pwm_timebase

Period timebase for the motor PWM output path. It generates the shared `timer_value` ramp that the per-channel compare stages test against, and the one-cycle `compare_value_latch` strobe that those stages use to load new duty values. Period and prescale settings are double-buffered and only take effect at a period boundary, so duty and period changes are glitch-free. It sits between the register interface (upstream) and the per-motor compare stages (downstream, one per output).

## Interface
- `TIMER_WIDTH`, 32, width of timer, period and `timer_value`
- `PRESCALE_WIDTH`, 16, width of the prescale divider setting
---
- `clk` in 1: single clock; everything is synchronous to its rising edge
- `rst` in 1: asynchronous, active-high reset
- `enable` in 1: level; 1 = run the timebase, 0 = stop and hold at zero
- `period_in` in `TIMER_WIDTH`: requested terminal count; timer counts 0..`period_in`
- `prescale_in` in `PRESCALE_WIDTH`: requested divider; timer advances every `prescale_in`+1 clocks
- `cfg_write` in 1: one-cycle pulse; captures `period_in` and `prescale_in` into the pending shadow registers
- `cfg_pending` out 1: 1 while a captured configuration is waiting for a period boundary
- `timer_value` out `TIMER_WIDTH`: registered ramp, fanned out to all compare stages
- `compare_value_latch` out 1: one-cycle strobe during the last clock before `timer_value` becomes 0 for a new period
- `running` out 1: 1 in state RUN

## Operation
- **Registers:**
  - pending_period and pending_prescale, loaded by `cfg_write`.
  - active_period and active_prescale, which control counting.
  - prescale_cnt, `timer_value`, and the state.
- **States:** IDLE, ARM, RUN.
  - **IDLE:** `timer_value`=0 and prescale_cnt=0. Moves to ARM when `enable`=1.
  - **ARM:** lasts exactly 1 cycle.
    - `compare_value_latch`=1 and `timer_value`=0.
    - On exit, if `cfg_pending` is set: active_* <= pending_* and `cfg_pending` clears.
    - Goes to RUN if `enable`=1, otherwise IDLE (no load happens in that case).
  - **RUN:** tick = (prescale_cnt == active_prescale).
    - When tick=1: prescale_cnt <= 0.
    - When tick=0: prescale_cnt increments.
    - On tick with `timer_value` < active_period: `timer_value` increments.
    - On tick with `timer_value` == active_period: this is the boundary cycle.
      - `compare_value_latch`=1.
      - Next edge: `timer_value` <= 0; active_* <= pending_* if `cfg_pending`; `cfg_pending` clears.
  - **`enable`=0 in ARM or RUN:** next state is IDLE and `timer_value` and prescale_cnt are cleared. Active config is retained and pending stays pending.
- **`compare_value_latch` decode:** a combinational decode of registered state only, equal to (state==ARM) | (state==RUN & tick & `timer_value`==active_period). It is never asserted in IDLE.
- **Period length:** (active_period+1)·(active_prescale+1) clocks.
- **Arithmetic:** unsigned compares only. `timer_value` never exceeds active_period, so there is no modular wrap at 2^`TIMER_WIDTH`.
- **`cfg_write` in any state:** overwrites pending_* and sets `cfg_pending`. Later writes before a boundary replace earlier ones; last write wins.
- **`cfg_write` in the boundary cycle or the ARM cycle:** the apply uses pending_* as registered *before* this write. The new write lands in pending_* and `cfg_pending` stays 1 for the next boundary. Write takes priority over clear.
- **active_period = 0:** `timer_value` stays 0 and the strobe occurs every tick.
- **active_prescale = 0:** a tick occurs every clock.

## Timing
- **Reset values (asynchronous):**
  - state=IDLE, `timer_value`=0, prescale_cnt=0.
  - active_*=0, pending_*=0.
  - `cfg_pending`=0, `compare_value_latch`=0, `running`=0.
- **Start-up:** `enable` is sampled 1 at edge N. ARM is cycle N+1 with strobe high. RUN starts at N+2 with `timer_value`=0.
- **Downstream alignment:** the strobe is high in the cycle before `timer_value` becomes 0. A compare stage latching on that edge therefore has its new compare in effect from `timer_value`=0 of the new period.
- **`cfg_pending` timing:** set 1 cycle after `cfg_write`; cleared on the edge that applies the config.
- **Stop latency:** from `enable` deassertion to `timer_value`=0 is 1 edge.
- **Reset mid-period:** immediate return to reset values. The active config is lost and returns to 0.

## Test plan
- **Reset defaults:** assert `rst` asynchronously mid-count → all outputs 0 within the same cycle. After release with `enable`=0, `timer_value` stays 0 and no strobe occurs.
- **Basic ramp:** `cfg_write` with period=3, prescale=0, then `enable`=1.
  - One ARM strobe, then `timer_value` runs 0,1,2,3,0,…
  - The strobe coincides with each `timer_value`=3; period = 4 clocks.
  - `cfg_pending` clears after ARM.
- **Prescale:** period=2, prescale=2 → each value is held 3 clocks, period = 9 clocks, one strobe per period on the last clock of value 2.
- **Deferred update:** running period=9; `cfg_write` period=4 at `timer_value`=5.
  - Count continues to 9 and `cfg_pending` stays 1 until the boundary.
  - After the boundary, the ramp runs 0..4.
- **Boundary collision:** `cfg_write` (period=7) in the exact boundary cycle while pending=5.
  - The next period uses 5.
  - `cfg_pending` stays 1 and the following period uses 7.
- **Stop/restart and degenerate cases:**
  - Drop `enable` mid-count → `timer_value`=0 next cycle and `running`=0.
  - Re-enable → ARM strobe again.
  - period=0, prescale=0 → `timer_value` constant 0 and strobe every cycle.

Source files
------------

// File: rtl/motor_pwm_timebase.sv
// motor_pwm_timebase
// Period timebase for the motor PWM output path. It produces the shared
// timer_value ramp (0..active period) and a one-cycle compare_value_latch
// strobe in the last clock before the ramp restarts at 0. Period/prescale
// settings are double-buffered and only applied at a period boundary
// (or on the ARM cycle at start-up).
//
// Ports:
//   clk                 - single clock, rising edge
//   rst                 - asynchronous, active-high reset
//   enable              - 1 = run, 0 = stop and hold timer at zero
//   period_in           - requested terminal count (timer counts 0..period)
//   prescale_in         - requested divider (advance every prescale+1 clocks)
//   cfg_write           - one-cycle pulse capturing period_in/prescale_in
//   cfg_pending         - captured config waiting for a period boundary
//   timer_value         - registered ramp for the compare stages
//   compare_value_latch - strobe in the cycle before timer_value returns to 0
//   running             - 1 while in RUN
module motor_pwm_timebase #(
  parameter int TIMER_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [TIMER_WIDTH-1:0]    period_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  input  logic                      cfg_write,
  output logic                      cfg_pending,
  output logic [TIMER_WIDTH-1:0]    timer_value,
  output logic                      compare_value_latch,
  output logic                      running
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [TIMER_WIDTH-1:0]    TIMER_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE   = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                state_r;
  logic [PRESCALE_WIDTH-1:0] prescale_cnt_r;
  logic [TIMER_WIDTH-1:0]    active_period_r;
  logic [PRESCALE_WIDTH-1:0] active_prescale_r;
  logic [TIMER_WIDTH-1:0]    pending_period_r;
  logic [PRESCALE_WIDTH-1:0] pending_prescale_r;

  logic tick_s;
  logic boundary_s;
  logic apply_s;

  // Tick / boundary / apply decode from registered state only.
  always_comb begin
    tick_s     = 1'b0;
    boundary_s = 1'b0;
    apply_s    = 1'b0;
    if (state_r == ST_RUN) begin
      tick_s     = (prescale_cnt_r == active_prescale_r);
      boundary_s = tick_s && (timer_value == active_period_r);
    end else begin
      tick_s     = 1'b0;
      boundary_s = 1'b0;
    end
    // A config is only applied when the timebase keeps running past the
    // boundary; a stop leaves the pending config pending.
    apply_s = enable && cfg_pending && ((state_r == ST_ARM) || boundary_s);
  end

  assign compare_value_latch = (state_r == ST_ARM) || boundary_s;
  assign running             = (state_r == ST_RUN);

  // State machine, prescale counter and timer ramp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      prescale_cnt_r <= {PRESCALE_WIDTH{1'b0}};
      timer_value    <= {TIMER_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          prescale_cnt_r <= {PRESCALE_WIDTH{1'b0}};
          timer_value    <= {TIMER_WIDTH{1'b0}};
          state_r        <= enable ? ST_ARM : ST_IDLE;
        end
        ST_ARM: begin
          prescale_cnt_r <= {PRESCALE_WIDTH{1'b0}};
          timer_value    <= {TIMER_WIDTH{1'b0}};
          state_r        <= enable ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (!enable) begin
            state_r        <= ST_IDLE;
            prescale_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            timer_value    <= {TIMER_WIDTH{1'b0}};
          end else if (tick_s) begin
            prescale_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            // timer_value never exceeds active_period, so equality is the wrap.
            if (boundary_s) begin
              timer_value <= {TIMER_WIDTH{1'b0}};
            end else begin
              timer_value <= timer_value + TIMER_ONE;
            end
          end else begin
            prescale_cnt_r <= prescale_cnt_r + PRE_ONE;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          prescale_cnt_r <= {PRESCALE_WIDTH{1'b0}};
          timer_value    <= {TIMER_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Pending shadow registers; a write in the apply cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_period_r   <= {TIMER_WIDTH{1'b0}};
      pending_prescale_r <= {PRESCALE_WIDTH{1'b0}};
      cfg_pending        <= 1'b0;
    end else if (cfg_write) begin
      pending_period_r   <= period_in;
      pending_prescale_r <= prescale_in;
      cfg_pending        <= 1'b1;
    end else if (apply_s) begin
      cfg_pending        <= 1'b0;
    end
  end

  // Active config; loaded from the pending values held before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_period_r   <= {TIMER_WIDTH{1'b0}};
      active_prescale_r <= {PRESCALE_WIDTH{1'b0}};
    end else if (apply_s) begin
      active_period_r   <= pending_period_r;
      active_prescale_r <= pending_prescale_r;
    end
  end

endmodule
